imem_dual_arbiter: RTL
======================

// Module: imem_dual_arbiter
// PURPOSE
//  Shares one instruction-memory read port between two core copies (requester 0/1) in the
//  two-copy security harness. Round-robin grant with valid/ready request handshake, fixed-latency
//  pipelined memory, tag-routed responses. Sits between coretop1/coretop2 imem ports and program ROM.
// PARAMETERS
//  ADDR_W    32  request address width (bytes)
//  DATA_W    32  instruction word width
//  MEM_LAT   1   memory read latency in cycles, legal 1..4
//  CNT_W     16  width of per-requester grant counters
//  SKEW_MAX  2   max |grant_cnt0-grant_cnt1| tolerated (LOCKSTEP_CHECK_EN only)
// PORTS
//  clock          in   1       rising-edge clock
//  reset_n        in   1       async active-low reset
//  req_valid[0:1] in   1 each  requester k has a fetch pending
//  req_addr[0:1]  in   ADDR_W  fetch byte address, stable while valid && !ready
//  req_ready[0:1] out  1 each  grant; transfer occurs when valid && ready
//  resp_valid[0:1] out 1 each  response for requester k, one-cycle pulse
//  resp_data      out  DATA_W  shared response data, qualified by resp_valid[k]
//  mem_req_valid  out  1       read issued to memory this cycle
//  mem_req_addr   out  ADDR_W  read address to memory
//  mem_req_ready  in   1       memory accepts a read this cycle
//  mem_resp_data  in   DATA_W  read data, valid exactly MEM_LAT cycles after accept
//  grant_cnt0/1   out  CNT_W   grants to requester 0/1, saturating
//  diverge        out  1       sticky lockstep divergence flag (0 when feature off)
//  diverge_idx    out  CNT_W   grant index at first divergence (0 when feature off)
// BEHAVIOUR
//  - Reset (reset_n low, async): req_ready=0, resp_valid=0, mem_req_valid=0, mem_req_addr=0,
//    grant_cnt*=0, diverge=0, diverge_idx=0, last_grant=1 (so requester 0 wins first tie).
//    Tag pipeline cleared: in-flight reads are dropped; no response for them after reset release.
//  - Arbitration (combinational on current inputs, registered last_grant):
//    only one valid -> that one; both valid -> the one != last_grant; none -> no grant.
//    Grant issued only if mem_req_ready=1; req_ready[k]=1 for granted k only, never both.
//  - mem_req_valid = any grant candidate valid; mem_req_addr = candidate's req_addr (0 when idle).
//  - On transfer: last_grant<=k; grant_cntk++ (holds at all-ones); tag {valid,k} enters
//    MEM_LAT-deep shift register. Throughput one grant per cycle, up to MEM_LAT reads in flight.
//  - Response: when tag at stage MEM_LAT is valid, resp_valid[tag.k]=1, resp_data=mem_resp_data,
//    same cycle as memory data. No response backpressure; requesters must accept.
//  - Ordering: responses per requester return in grant order. Fairness: with both valid and
//    mem_req_ready high every cycle, grants strictly alternate; max wait 1 grant.
//  - mem_req_ready=0: no grant, last_grant unchanged, tags still shift (in-flight reads complete).
//  - resp_data = 0 in cycles with no resp_valid.
// CONFIGURATION
//  LOCKSTEP_CHECK_EN defined:
//   - per-requester last_addr register captured on each transfer.
//   - After any transfer that makes grant_cnt0==grant_cnt1 (nonzero), if last_addr0!=last_addr1
//     set diverge=1, diverge_idx=grant_cnt0 (first event only; sticky until reset).
//   - If |grant_cnt0-grant_cnt1| > SKEW_MAX set diverge, diverge_idx=max(grant_cnt0,grant_cnt1).
//   - Arbitration and data path unchanged; diverge never stalls grants.
//  LOCKSTEP_CHECK_EN undefined: no last_addr/compare logic; diverge and diverge_idx tied to 0.
// TESTING
//  1 Both valid, addr0=0x04, addr1=0x04, mem_ready=1, MEM_LAT=1 -> grants 0,1,0,1 alternate,
//    resp_valid[0] cycle after first grant with ROM[1]; grant_cnt0=grant_cnt1=2 after 4 cycles.
//  2 Only req1 valid for 5 cycles -> 5 consecutive grants to 1, grant_cnt1=5, grant_cnt0=0.
//  3 mem_req_ready low 3 cycles with both valid -> no req_ready, 2 in-flight MEM_LAT=2 reads still
//    respond; on ready high, grant resumes with requester != last_grant.
//  4 reset_n dropped while 2 reads in flight -> resp_valid stays 0, counters 0 immediately;
//    first grant after release goes to requester 0.
//  5 LOCKSTEP_CHECK_EN: req0 addr 0x08, req1 addr 0x0C, one grant each -> diverge=1, diverge_idx=1;
//    later matching pairs leave diverge_idx=1.
//  6 LOCKSTEP_CHECK_EN, SKEW_MAX=2: only req0 valid 3 grants -> diverge=1, diverge_idx=3.

Source files
------------

// File: rtl/imem_dual_arbiter.sv
// imem_dual_arbiter: shares one instruction-memory read port between two
// core copies. Round-robin grant, fixed-latency pipelined memory and
// tag-routed responses. The optional lockstep divergence checker is built
// only when LOCKSTEP_CHECK_EN is defined; otherwise diverge/diverge_idx are 0.
module imem_dual_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MEM_LAT  = 1,
    parameter int CNT_W    = 16,
    parameter int SKEW_MAX = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [1:0]        req_valid,
    input  logic [ADDR_W-1:0] req_addr [2],
    output logic [1:0]        req_ready,
    output logic [1:0]        resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_req_ready,
    input  logic [DATA_W-1:0] mem_resp_data,
    output logic [CNT_W-1:0]  grant_cnt0,
    output logic [CNT_W-1:0]  grant_cnt1,
    output logic              diverge,
    output logic [CNT_W-1:0]  diverge_idx
);

    if (MEM_LAT < 1 || MEM_LAT > 4 || SKEW_MAX < 0) begin : g_bad_param
        $error("imem_dual_arbiter: MEM_LAT must be 1..4 and SKEW_MAX non-negative");
    end

    logic               last_grant;
    logic               cand_valid;
    logic               cand_k;
    logic               transfer;
    logic [MEM_LAT-1:0] tag_v;
    logic [MEM_LAT-1:0] tag_k;
    logic [CNT_W-1:0]   cnt_next0;
    logic [CNT_W-1:0]   cnt_next1;

    // Candidate selection: round-robin on a tie, memory port mirrors the candidate.
    always_comb begin
        cand_valid    = reset_n && (req_valid != 2'b00);
        cand_k        = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
        mem_req_valid = cand_valid;
        mem_req_addr  = cand_valid ? req_addr[cand_k] : '0;
        transfer      = cand_valid && mem_req_ready;
        req_ready     = 2'b00;
        if (transfer) begin
            req_ready = cand_k ? 2'b10 : 2'b01;
        end
    end

    // Saturating next values of the grant counters, shared with the lockstep checker.
    always_comb begin
        cnt_next0 = grant_cnt0;
        cnt_next1 = grant_cnt1;
        if (transfer && !cand_k && grant_cnt0 != '1) begin
            cnt_next0 = grant_cnt0 + 1'b1;
        end
        if (transfer && cand_k && grant_cnt1 != '1) begin
            cnt_next1 = grant_cnt1 + 1'b1;
        end
    end

    // Arbitration history and grant counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= 1'b1;
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (transfer) begin
                last_grant <= cand_k;
            end
            grant_cnt0 <= cnt_next0;
            grant_cnt1 <= cnt_next1;
        end
    end

    // Tag pipeline tracking which requester owns each in-flight read.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tag_v <= '0;
            tag_k <= '0;
        end else begin
            tag_v[0] <= transfer;
            tag_k[0] <= cand_k;
            for (int unsigned i = 1; i < MEM_LAT; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_k[i] <= tag_k[i-1];
            end
        end
    end

    // Route memory data to the owner of the read completing this cycle.
    always_comb begin
        resp_valid = 2'b00;
        resp_data  = '0;
        if (tag_v[MEM_LAT-1]) begin
            resp_valid = tag_k[MEM_LAT-1] ? 2'b10 : 2'b01;
            resp_data  = mem_resp_data;
        end
    end

`ifdef LOCKSTEP_CHECK_EN
    logic [ADDR_W-1:0] last_addr0;
    logic [ADDR_W-1:0] last_addr1;
    logic [ADDR_W-1:0] addr_next0;
    logic [ADDR_W-1:0] addr_next1;
    logic [CNT_W-1:0]  skew;
    logic [CNT_W-1:0]  cnt_max;

    // Post-transfer view of addresses and counter skew used by the checker.
    always_comb begin
        addr_next0 = (transfer && !cand_k) ? req_addr[0] : last_addr0;
        addr_next1 = (transfer &&  cand_k) ? req_addr[1] : last_addr1;
        if (cnt_next0 >= cnt_next1) begin
            skew    = cnt_next0 - cnt_next1;
            cnt_max = cnt_next0;
        end else begin
            skew    = cnt_next1 - cnt_next0;
            cnt_max = cnt_next1;
        end
    end

    // Sticky divergence flag: records only the first mismatch or excess skew.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_addr0  <= '0;
            last_addr1  <= '0;
            diverge     <= 1'b0;
            diverge_idx <= '0;
        end else begin
            last_addr0 <= addr_next0;
            last_addr1 <= addr_next1;
            if (transfer && !diverge) begin
                if (cnt_next0 == cnt_next1 && cnt_next0 != '0 && addr_next0 != addr_next1) begin
                    diverge     <= 1'b1;
                    diverge_idx <= cnt_next0;
                end else if (skew > CNT_W'(SKEW_MAX)) begin
                    diverge     <= 1'b1;
                    diverge_idx <= cnt_max;
                end
            end
        end
    end
`else
    assign diverge     = 1'b0;
    assign diverge_idx = '0;
`endif

endmodule
